// File: rtl/router_pkg.sv
// Shared router constants: port indices and default field widths for the switch scheduler.
package router_pkg;
  localparam int PORT_N     = 0;
  localparam int PORT_S     = 1;
  localparam int PORT_W     = 2;
  localparam int PORT_E     = 3;
  localparam int PORT_LOCAL = 4;

  localparam int VC_BITS   = $clog2(4);
  localparam int CRED_BITS = $clog2(4 + 1);
endpackage

// File: rtl/rr_switch_scheduler_rr_pick.sv
// Combinational round-robin pick: first set req bit at or after ptr, wrapping.
import router_pkg::*;

module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt_onehot,
  output logic [IW-1:0] gnt_idx
);

  logic found;
  int   idx;

  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    found      = 1'b0;
    idx        = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        found           = 1'b1;
        gnt_onehot[idx] = 1'b1;
        gnt_idx         = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/rr_switch_scheduler.sv
// Separable input-first crossbar scheduler with per-output downstream credit gating.
// One-cycle latency: winners sampled at a posedge appear on the registered outputs after it.
import router_pkg::*;

module rr_switch_scheduler #(
  parameter int NUM_PORTS   = 5,
  parameter int NUM_VC      = 4,
  parameter int MAX_CREDITS = NUM_VC,
  parameter int VC_BITS     = $clog2(NUM_VC),
  parameter int CRED_BITS   = $clog2(MAX_CREDITS + 1)
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic [NUM_PORTS*NUM_VC-1:0]                vc_req,
  input  logic [NUM_PORTS*NUM_VC-1:0][NUM_PORTS-1:0] vc_dst_port,
  input  logic [NUM_PORTS-2:0]                       dwnstr_router_increment,
  output logic [NUM_PORTS-1:0]                       grant_valid,
  output logic [NUM_PORTS-1:0][VC_BITS-1:0]          grant_vc,
  output logic [NUM_PORTS-1:0][NUM_PORTS-1:0]        xbar_sel,
  output logic [NUM_PORTS-2:0][CRED_BITS-1:0]        out_credit,
  output logic                                       credit_overflow
);

  localparam int NP = NUM_PORTS;
  localparam int PW = $clog2(NUM_PORTS);

  logic [NP-1:0][NUM_VC-1:0]  elig;
  logic [NP-1:0][NUM_VC-1:0]  in_oh;
  logic [NP-1:0][VC_BITS-1:0] in_idx;
  logic [NP-1:0][VC_BITS-1:0] in_ptr;
  logic [NP-1:0]              cand_vld;
  logic [NP-1:0][NP-1:0]      cand_dst;
  logic [NP-1:0][NP-1:0]      out_req;   // [output][input]
  logic [NP-1:0][NP-1:0]      out_oh;    // [output][input]
  logic [NP-1:0][PW-1:0]      out_idx;
  logic [NP-1:0][PW-1:0]      out_ptr;
  logic [NP-1:0]              win;
  logic [NP-1:0]              has_credit;

  // The eject port has no downstream buffer, so it never runs out of credit.
  always_comb begin
    has_credit = '1;
    for (int o = 0; o < NP - 1; o++) begin
      has_credit[o] = (out_credit[o] != '0);
    end
    for (int i = 0; i < NP; i++) begin
      for (int j = 0; j < NUM_VC; j++) begin
        elig[i][j] = vc_req[i*NUM_VC+j] && $onehot(vc_dst_port[i*NUM_VC+j])
                     && |(vc_dst_port[i*NUM_VC+j] & has_credit);
      end
    end
  end

  for (genvar gi = 0; gi < NP; gi++) begin : g_in_stage
    rr_pick #(.N(NUM_VC)) u_in_pick (
      .req        (elig[gi]),
      .ptr        (in_ptr[gi]),
      .gnt_onehot (in_oh[gi]),
      .gnt_idx    (in_idx[gi])
    );
  end

  always_comb begin
    cand_vld = '0;
    cand_dst = '0;
    out_req  = '0;
    win      = '0;
    for (int i = 0; i < NP; i++) begin
      cand_vld[i] = |in_oh[i];
      cand_dst[i] = vc_dst_port[i*NUM_VC+int'(in_idx[i])];
    end
    for (int o = 0; o < NP; o++) begin
      for (int i = 0; i < NP; i++) begin
        out_req[o][i] = cand_vld[i] && cand_dst[i][o];
      end
    end
    for (int i = 0; i < NP; i++) begin
      for (int o = 0; o < NP; o++) begin
        win[i] = win[i] | out_oh[o][i];
      end
    end
  end

  for (genvar go = 0; go < NP; go++) begin : g_out_stage
    rr_pick #(.N(NP)) u_out_pick (
      .req        (out_req[go]),
      .ptr        (out_ptr[go]),
      .gnt_onehot (out_oh[go]),
      .gnt_idx    (out_idx[go])
    );
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      grant_valid     <= '0;
      grant_vc        <= '0;
      xbar_sel        <= '0;
      in_ptr          <= '0;
      out_ptr         <= '0;
      credit_overflow <= 1'b0;
      for (int o = 0; o < NP - 1; o++) begin
        out_credit[o] <= CRED_BITS'(MAX_CREDITS);
      end
    end else begin
      grant_valid <= win;
      xbar_sel    <= out_oh;
      for (int i = 0; i < NP; i++) begin
        grant_vc[i] <= win[i] ? in_idx[i] : '0;
        if (win[i]) begin
          in_ptr[i] <= VC_BITS'((int'(in_idx[i]) + 1) % NUM_VC);
        end
      end
      for (int o = 0; o < NP; o++) begin
        if (out_oh[o] != '0) begin
          out_ptr[o] <= PW'((int'(out_idx[o]) + 1) % NP);
        end
      end
      // A grant and a return in the same cycle cancel out.
      for (int o = 0; o < NP - 1; o++) begin
        if ((out_oh[o] != '0) && !dwnstr_router_increment[o]) begin
          out_credit[o] <= out_credit[o] - 1'b1;
        end else if ((out_oh[o] == '0) && dwnstr_router_increment[o]) begin
          if (out_credit[o] == CRED_BITS'(MAX_CREDITS)) begin
            credit_overflow <= 1'b1;
          end else begin
            out_credit[o] <= out_credit[o] + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: doc/rr_switch_scheduler.md
Name: rr_switch_scheduler

Overview:
- Separable input-first switch scheduler for the router crossbar, with downstream-credit gating.
- Each cycle it picks at most one VC per input port and at most one input per output port.
- Registered outputs: per-input VC grant (drives buffer read), per-output one-hot input select (drives crossbar).
- Owns per-output credit counters, decremented on grant and incremented by dwnstr_router_increment.

Parameters:
- NUM_PORTS, 5, router ports; index NUM_PORTS-1 is LOCAL (eject), indices 0..NUM_PORTS-2 are N,S,W,E.
- NUM_VC, 4, VCs per input port.
- MAX_CREDITS, NUM_VC, downstream credits per non-local output at reset.
- VC_BITS, $clog2(NUM_VC), VC index width.
- CRED_BITS, $clog2(MAX_CREDITS+1), credit counter width.

Ports:
- clk  in  1  clock, all logic on posedge.
- reset  in  1  synchronous, active-low; reset==0 at posedge clears all state.
- vc_req  in  NUM_PORTS*NUM_VC  request bit for VC (i*NUM_VC+j).
- vc_dst_port  in  [NUM_PORTS*NUM_VC][NUM_PORTS]  one-hot output port per VC.
- dwnstr_router_increment  in  NUM_PORTS-1  one credit returned for non-local output o.
- grant_valid  out  NUM_PORTS  input i wins this cycle.
- grant_vc  out  [NUM_PORTS][VC_BITS]  VC index granted at input i.
- xbar_sel  out  [NUM_PORTS][NUM_PORTS]  per output o, one-hot winning input; all zero when idle.
- out_credit  out  [NUM_PORTS-1][CRED_BITS]  current credit count per non-local output.
- credit_overflow  out  1  sticky error flag.

Behaviour:
- Reset values: grant_valid=0, grant_vc=0, xbar_sel=0, out_credit=MAX_CREDITS, credit_overflow=0, all RR pointers=0.
- Eligibility: VC (i,j) is eligible if vc_req=1, vc_dst_port is exactly one-hot, and the target output has credit. LOCAL always has credit.
- A zero or multi-hot vc_dst_port makes that VC ineligible; it is silently ignored.
- Input stage (combinational): per input i, round-robin among eligible VCs starting at in_ptr[i], giving one candidate request per input.
- Output stage (combinational): per output o, round-robin among inputs whose candidate targets o, starting at out_ptr[o].
- Latency: one cycle. Winners sampled at posedge t appear on grant_valid/grant_vc/xbar_sel during cycle t+1; outputs are registered only.
- Pointer update on a winning grant only:
  - out_ptr[o] <= (winner+1) mod NUM_PORTS.
  - in_ptr[i] <= (granted VC+1) mod NUM_VC.
  - An input whose candidate lost keeps its in_ptr.
- Credits, per non-local output o, on each posedge:
  - grant only: decrement by 1.
  - increment only: add 1.
  - grant and increment in the same cycle: count unchanged.
- Credit eligibility uses the registered count, so a count of 1 permits exactly one grant before the next return arrives.
- Credit overflow: an increment at MAX_CREDITS with no simultaneous grant holds the count at MAX_CREDITS and sets credit_overflow. credit_overflow stays set until reset.
- A grant never drops a credit count below 0; this follows from the eligibility rule.
- No request: outputs return to 0 the following cycle.
- Reset asserted mid-operation: everything returns to reset values at that edge; in-flight grants are dropped.
- Invariants: each xbar_sel[o] has popcount ≤1; each input appears in at most one xbar_sel[o]; grant_valid[i] == OR over o of xbar_sel[o][i].

Decomposition:
- router_pkg holds: port index constants (PORT_N=0, PORT_S=1, PORT_W=2, PORT_E=3, PORT_LOCAL=4), VC_BITS, CRED_BITS.
- One sub-module, rr_pick (parameter N): combinational round-robin pick with inputs req[N] and ptr, outputs gnt_onehot and gnt_idx.
  - NUM_PORTS instances for the input stage (N=NUM_VC).
  - NUM_PORTS instances for the output stage (N=NUM_PORTS).
- Pointers and credit registers live in rr_switch_scheduler.

Test Plan:
- Reset and single grant: drive reset=0 for 2 cycles, then reset=1.
  - Expect all outputs 0 and out_credit all 4.
  - Then set vc_req bit 1 (input 0, VC1) with dst N (00001). Next cycle expect grant_valid=00001, grant_vc[0]=1, xbar_sel[0]=00001, and one cycle later out_credit[0]=3.
- Output contention: inputs 1, 2 and 3 each hold VC0 toward E every cycle, with a credit return each cycle. xbar_sel[3] must rotate 00010 → 00100 → 01000 → 00010.
- VC rotation: input 0 has VC0..VC3 all requesting LOCAL continuously. grant_vc[0] must cycle 0,1,2,3,0 and out_credit must stay unchanged.
- Credit exhaustion: 4 grants to S with no returns gives out_credit[1]=0, and the persisting request gets no grant.
  - Pulse dwnstr_router_increment[1] once: exactly one grant follows, then credit is 0 again.
- Simultaneous grant and return: at out_credit[2]=2, a grant to W coincides with increment[2]=1; out_credit[2] must remain 2.
- Malformed and overflow cases:
  - dst 00011 on an otherwise idle router yields no grant.
  - An increment at out_credit=4 keeps 4 and sets credit_overflow=1 until reset.
